lsu_align_unit: RTL and testbench
=================================

Name: lsu_align_unit

Overview:
- Load/store unit between the EX/MEM pipeline register and a byte-enabled, word-organised data memory with synchronous read.
- Accepts one byte, half or word request per handshake and converts it to one or two aligned word accesses with byte enables.
- Merges load data, applies sign/zero extension, and returns a registered response with a fault flag.
- Replaces the combinational alignment check of the single-cycle data path in the pipelined core.

Parameters:
- MEM_BYTES, 1024, data memory size in bytes; power of two, multiple of 4.
- AW, 32, request address width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend load (LBU/LHU); ignored for stores and words.
- req_addr  in  AW  byte address.
- req_wdata  in  32  store data, right-justified.
- mem_req  out  1  memory access this cycle.
- mem_we  out  1  write strobe.
- mem_addr  out  AW  word-aligned address, bits [1:0] = 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned write data.
- mem_rdata  in  32  read data, valid the cycle after a read mem_req.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- rsp_fault  out  1  access rejected; memory untouched.

Behaviour:
- Reset values: req_ready=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0. FSM resets to IDLE.
- Reset mid-operation abandons the request. A second access not yet issued is never issued.
- FSM states: IDLE, ISSUE0, ISSUE1, DRAIN, RESP.
  - req_ready=1 only in IDLE.
  - Handshake when req_valid && req_ready: latch all req_* fields.
- Address split:
  - o = addr[1:0]; n = 1/2/4 bytes.
  - be8 = ((1<<n)-1)<<o, 8 bits.
  - wd64 = zero-extended wdata << 8*o.
  - Access 0 uses word addr&~3, be8[3:0], wd64[31:0].
  - Access 1 uses word +4, be8[7:4], wd64[63:32].
  - split = be8[7:4] != 0.
- Fault conditions, decided at accept:
  - size==11, or addr+n-1 >= MEM_BYTES (no wrap-around).
  - Without split enabled (see Optional Feature): any misaligned access also faults.
  - A faulting request goes IDLE -> RESP with no mem_req issued.
- Transitions:
  - IDLE -> ISSUE0 on accept (non-fault).
  - ISSUE0 -> ISSUE1 if split; else DRAIN for a load, RESP for a store.
  - ISSUE1 -> DRAIN for a load, RESP for a store.
  - DRAIN -> RESP.
  - RESP -> IDLE.
- mem_req=1 exactly in ISSUE0/ISSUE1. mem_we=req_write. Outputs are combinational from state plus latched fields.
- Load data capture: mem_rdata from the access-0 read is captured in the following cycle as w0, and likewise w1 for access 1. Merge: ({w1,w0} >> 8*o)[31:0], then extend per size and unsigned. Result is registered into rsp_rdata.
- rsp_valid is high in RESP only, for one cycle. rsp_* hold until the next RESP.
- Latency (accept cycle T, response at):
  - aligned store T+2; split store T+3.
  - aligned load T+3; split load T+4.
  - fault T+1.
- Throughput: at most one request every latency+1 cycles.

Optional Feature:
- LSU_MISALIGN_SPLIT_EN defined: misaligned in-range accesses are split as above.
- Not defined: any access with be8[7:4]!=0, or half with o odd, or word with o!=0, faults. ISSUE1 is unreachable and may be removed.

Decomposition:
- Package lsu_pkg: typedef enum for size (SZ_B, SZ_H, SZ_W), typedef enum for FSM state, constant for the fault size code.
- One sub-module, lsu_load_extract: combinational merge/shift/extend of {w1,w0}, o, size and unsigned into 32-bit load data.

Test Plan:
- Word load from addr 0x10, memory word 0x11223344 -> single mem_req, be=1111; rsp_valid at T+3 with 0x11223344, fault=0.
- LB from 0x13, byte 0x80 -> be=1000, rdata=0xFFFFFF80. LBU same address -> 0x00000080.
- SH 0xBEEF at 0x22 -> mem_addr=0x20, be=1100, wdata=0xBEEF0000; rsp at T+2; readback LHU gives 0x0000BEEF.
- With LSU_MISALIGN_SPLIT_EN, SW 0xAABBCCDD at 0x0D:
  - access 0: addr 0x0C, be=1110, wdata=0xBBCCDD00.
  - access 1: addr 0x10, be=0001, wdata=0x000000AA.
  - LW 0x0D returns 0xAABBCCDD at T+4.
  - Without the macro, same request -> rsp_fault=1 at T+1, no mem_req.
- Word load at 0x3FE (MEM_BYTES=1024), and size=11 at 0x0 -> fault=1 at T+1, no mem_req.
- rst asserted in ISSUE0 of a split store -> next cycle mem_req=0, req_ready=0 during reset, access 1 never issued, only access 0 bytes modified.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store alignment unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } lsu_size_e;

    localparam logic [1:0] SZ_FAULT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        ISSUE1,
        DRAIN,
        RESP
    } lsu_state_e;

    // Byte-enable mask across two consecutive words.
    function automatic logic [7:0] lsu_be8(input logic [1:0] sz,
                                           input logic [1:0] o);
        logic [7:0] m;
        unique case (1'b1)
            (sz == SZ_B): m = 8'h01;
            (sz == SZ_H): m = 8'h03;
            default:      m = 8'h0F;
        endcase
        return m << o;
    endfunction

    function automatic logic [1:0] lsu_nm1(input logic [1:0] sz);
        logic [1:0] n;
        unique case (1'b1)
            (sz == SZ_B): n = 2'd0;
            (sz == SZ_H): n = 2'd1;
            default:      n = 2'd3;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_align_unit_extract.sv
// Load merge: shifts {w1,w0} down to the request offset and extends.
module lsu_load_extract
    import lsu_pkg::*;
(
    input  logic [31:0] w0_i,
    input  logic [31:0] w1_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    output logic [31:0] data_o
);

    logic [31:0] sh;

    assign sh = 32'({w1_i, w0_i} >> {off_i, 3'b000});

    always_comb begin
        data_o = sh;
        unique case (1'b1)
            (size_i == SZ_B): data_o = {{24{sh[7] & ~uns_i}}, sh[7:0]};
            (size_i == SZ_H): data_o = {{16{sh[15] & ~uns_i}}, sh[15:0]};
            default:          data_o = sh;
        endcase
    end

endmodule

// File: rtl/lsu_align_unit.sv
// Byte/half/word LSU issuing aligned word accesses with byte enables.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses in two.
module lsu_align_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_fault
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam logic [AW:0] LIMIT = (AW+1)'(MEM_BYTES);

    lsu_state_e    state_q, state_d;
    logic          write_q, uns_q;
    logic [1:0]    size_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q, w0_q, rsp_rdata_q;
    logic          rsp_fault_q;

    logic          accept, in_split, in_fault;
    logic [1:0]    in_o;
    logic [7:0]    in_be8;
    logic [AW:0]   in_last;

    logic [1:0]    o;
    logic [7:0]    be8;
    logic [63:0]   wd64;
    logic          split;
    logic [AW-1:0] word0;
    logic [31:0]   ld_w0, ld_w1, ld_data;

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    assign in_o     = req_addr[1:0];
    assign in_be8   = lsu_be8(req_size, in_o);
    assign in_split = |in_be8[7:4];
    assign in_last  = {1'b0, req_addr}
                    + {{(AW-1){1'b0}}, lsu_nm1(req_size)};

    always_comb begin
        in_fault = (req_size == SZ_FAULT) || (in_last >= LIMIT);
        if (!SPLIT_EN && (in_split
                || (req_size == SZ_H && in_o[0])
                || (req_size == SZ_W && in_o != 2'b00)))
            in_fault = 1'b1;
    end

    assign o     = addr_q[1:0];
    assign be8   = lsu_be8(size_q, o);
    assign wd64  = {32'h0, wdata_q} << {o, 3'b000};
    assign split = |be8[7:4];
    assign word0 = {addr_q[AW-1:2], 2'b00};

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        unique case (state_q)
            IDLE: begin
                if (accept)
                    state_d = in_fault ? RESP : ISSUE0;
            end
            ISSUE0: begin
                mem_req   = 1'b1;
                mem_we    = write_q;
                mem_addr  = word0;
                mem_be    = be8[3:0];
                mem_wdata = wd64[31:0];
                if (split)
                    state_d = ISSUE1;
                else
                    state_d = write_q ? RESP : DRAIN;
            end
            ISSUE1: begin
                mem_req   = 1'b1;
                mem_we    = write_q;
                mem_addr  = word0 + AW'(4);
                mem_be    = be8[7:4];
                mem_wdata = wd64[63:32];
                state_d   = write_q ? RESP : DRAIN;
            end
            DRAIN:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // In DRAIN the bus carries the last read; a split load parked w0 earlier.
    assign ld_w0 = split ? w0_q : mem_rdata;
    assign ld_w1 = split ? mem_rdata : 32'h0;

    lsu_load_extract u_extract (
        .w0_i   (ld_w0),
        .w1_i   (ld_w1),
        .off_i  (o),
        .size_i (size_q),
        .uns_i  (uns_q),
        .data_o (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            w0_q        <= '0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q <= req_write;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == ISSUE1)
                w0_q <= mem_rdata;
            // Entry from IDLE can only be a rejected request.
            if (state_d == RESP) begin
                rsp_fault_q <= (state_q == IDLE);
                rsp_rdata_q <= (state_q == DRAIN) ? ld_data : 32'h0;
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_lsu_align_unit.sv
// Directed bench for lsu_align_unit with a byte-array memory model.
module tb_lsu_align_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;

    int ntests = 0;
    int nfail  = 0;
    int base;
    int lat;
    logic rsp_seen;

    logic [7:0]  mem [0:1023];
    logic [31:0] acc_addr [$];
    logic [31:0] acc_be   [$];
    logic [31:0] acc_wd   [$];
    logic [31:0] acc_we   [$];

    always #5 clk = ~clk;

    lsu_align_unit #(.MEM_BYTES(1024), .AW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_fault    (rsp_fault)
    );

    always @(posedge clk) begin
        if (mem_req) begin
            acc_addr.push_back(mem_addr);
            acc_be.push_back({28'h0, mem_be});
            acc_wd.push_back(mem_wdata);
            acc_we.push_back({31'h0, mem_we});
            if (mem_we) begin
                for (int k = 0; k < 4; k++)
                    if (mem_be[k])
                        mem[mem_addr[9:0] + 10'(k)] <= mem_wdata[8*k +: 8];
            end else begin
                mem_rdata <= {mem[mem_addr[9:0] + 10'd3], mem[mem_addr[9:0] + 10'd2],
                              mem[mem_addr[9:0] + 10'd1], mem[mem_addr[9:0]]};
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic run(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       output int l);
        int k;
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        base         = acc_addr.size();
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        l = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                l = i;
                break;
            end
        end
    endtask

    function automatic int nacc();
        return acc_addr.size() - base;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem_rdata    = 32'h0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 32'h0);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_be", {28'h0, mem_be}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_fault", {31'h0, rsp_fault}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", {31'h0, req_ready}, 32'h1);

        mem[16] = 8'h44; mem[17] = 8'h33; mem[18] = 8'h22; mem[19] = 8'h11;
        mem[1023] = 8'h7F;

        run(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat);
        check("lw_lat", lat, 3);
        check("lw_data", rsp_rdata, 32'h11223344);
        check("lw_fault", {31'h0, rsp_fault}, 32'h0);
        check("lw_nacc", nacc(), 1);
        check("lw_addr", acc_addr[base], 32'h10);
        check("lw_be", acc_be[base], 32'hF);
        check("lw_we", acc_we[base], 32'h0);

        mem[19] = 8'h80;
        run(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat);
        check("lb_lat", lat, 3);
        check("lb_be", acc_be[base], 32'h8);
        check("lb_addr", acc_addr[base], 32'h10);
        check("lb_data", rsp_rdata, 32'hFFFFFF80);
        run(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat);
        check("lbu_data", rsp_rdata, 32'h00000080);

        run(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, lat);
        check("sh_lat", lat, 2);
        check("sh_nacc", nacc(), 1);
        check("sh_addr", acc_addr[base], 32'h20);
        check("sh_be", acc_be[base], 32'hC);
        check("sh_wdata", acc_wd[base], 32'hBEEF0000);
        check("sh_we", acc_we[base], 32'h1);
        check("sh_rdata", rsp_rdata, 32'h0);
        check("sh_fault", {31'h0, rsp_fault}, 32'h0);
        run(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, lat);
        check("lhu_data", rsp_rdata, 32'h0000BEEF);
        run(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, lat);
        check("lh_data", rsp_rdata, 32'hFFFFBEEF);

        run(1'b1, 2'b10, 1'b0, 32'h0D, 32'hAABBCCDD, lat);
`ifdef LSU_MISALIGN_SPLIT_EN
        check("sws_lat", lat, 3);
        check("sws_nacc", nacc(), 2);
        check("sws_a0_addr", acc_addr[base], 32'h0C);
        check("sws_a0_be", acc_be[base], 32'hE);
        check("sws_a0_wd", acc_wd[base], 32'hBBCCDD00);
        check("sws_a1_addr", acc_addr[base+1], 32'h10);
        check("sws_a1_be", acc_be[base+1], 32'h1);
        check("sws_a1_wd", acc_wd[base+1], 32'h000000AA);
        check("sws_fault", {31'h0, rsp_fault}, 32'h0);
        run(1'b0, 2'b10, 1'b0, 32'h0D, 32'h0, lat);
        check("lws_lat", lat, 4);
        check("lws_nacc", nacc(), 2);
        check("lws_data", rsp_rdata, 32'hAABBCCDD);
        run(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, lat);
        check("lh21_fault", {31'h0, rsp_fault}, 32'h0);
        check("lh21_data", rsp_rdata, 32'hFFFFEF00);
`else
        check("swm_lat", lat, 1);
        check("swm_fault", {31'h0, rsp_fault}, 32'h1);
        check("swm_nacc", nacc(), 0);
        check("swm_rdata", rsp_rdata, 32'h0);
        run(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, lat);
        check("lh21_lat", lat, 1);
        check("lh21_fault", {31'h0, rsp_fault}, 32'h1);
        check("lh21_nacc", nacc(), 0);
`endif

        run(1'b0, 2'b10, 1'b0, 32'h3FE, 32'h0, lat);
        check("oor_lat", lat, 1);
        check("oor_fault", {31'h0, rsp_fault}, 32'h1);
        check("oor_nacc", nacc(), 0);
        run(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, lat);
        check("sz11_lat", lat, 1);
        check("sz11_fault", {31'h0, rsp_fault}, 32'h1);
        check("sz11_nacc", nacc(), 0);
        run(1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0, lat);
        check("lb3ff_fault", {31'h0, rsp_fault}, 32'h0);
        check("lb3ff_data", rsp_rdata, 32'h0000007F);

        // Reset lands while the first access is on the bus.
        @(negedge clk);
        base         = acc_addr.size();
        req_valid    = 1'b1;
        req_write    = 1'b1;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
        req_addr     = 32'h0D;
`else
        req_addr     = 32'h40;
`endif
        req_wdata    = 32'h55667788;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rstmid_iss0", {31'h0, mem_req}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_req", {31'h0, mem_req}, 32'h0);
        check("rstmid_ready", {31'h0, req_ready}, 32'h0);
        rsp_seen = rsp_valid;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rsp_seen = rsp_seen | rsp_valid;
        end
        check("rstmid_nacc", nacc(), 1);
        check("rstmid_norsp", {31'h0, rsp_seen}, 32'h0);
        check("rstmid_ready2", {31'h0, req_ready}, 32'h1);
`ifdef LSU_MISALIGN_SPLIT_EN
        check("rstmid_mem", {mem[16], mem[15], mem[14], mem[13], mem[12]},
              {8'hAA, 8'h66, 8'h77, 8'h88, 8'h00});
`else
        check("rstmid_mem", {mem[67], mem[66], mem[65], mem[64]}, 32'h55667788);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
